// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory access path.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } memState_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } accSize_t;

    localparam logic [3:0] BE_ALL = 4'b1111;

    // AND-mask applied to the byte-offset bits to form the word-aligned bus address
    localparam logic [1:0] BUS_ADDR_ALIGN_MASK = 2'b00;

    function automatic logic [31:0] storeLanes(input accSize_t size, input logic [31:0] rt);
        logic [31:0] lanes;
        case (size)
            SZ_BYTE: lanes = {4{rt[7:0]}};
            SZ_HALF: lanes = {2{rt[15:0]}};
            default: lanes = rt;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align_ext.sv
// Combinational load-data lane select and sign/zero extension; shared with the
// uncached load path.
module load_align_ext
    import mips_mem_pkg::*;
(
    input  logic [31:0] rData,
    input  logic [1:0]  offset,
    input  accSize_t    size,
    input  logic        isUnsigned,
    output logic [31:0] result
);

    logic signed [7:0]  byteLane;
    logic signed [15:0] halfLane;

    always_comb begin
        byteLane = 8'sd0;
        case (offset)
            2'd0:    byteLane = rData[7:0];
            2'd1:    byteLane = rData[15:8];
            2'd2:    byteLane = rData[23:16];
            default: byteLane = rData[31:24];
        endcase
        halfLane = offset[1] ? rData[31:16] : rData[15:0];
    end

    always_comb begin
        result = rData;
        case (size)
            SZ_BYTE: result = isUnsigned ? {24'd0, byteLane} : {{24{byteLane[7]}}, byteLane};
            SZ_HALF: result = isUnsigned ? {16'd0, halfLane} : {{16{halfLane[15]}}, halfLane};
            default: result = rData;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: one request/grant/response bus
// transaction per load/store, stalling F..M while in flight. Optional ADDR_EXC_EN.
module mem_access_ctrl
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              ReqM,
    input  logic              IsLoadM,
    input  logic              IsStoreM,
    input  logic              IsLhShM,
    input  logic              IsLbSbM,
    input  logic              LoadUnsignedM,
    input  logic              FlushM,
    input  logic [ADDR_W-1:0] AddrM,
    input  logic [DATA_W-1:0] WDataM,
    input  logic [3:0]        BEInM,
    output logic              BusReq,
    output logic              BusWe,
    output logic [ADDR_W-1:0] BusAddr,
    output logic [3:0]        BusBE,
    output logic [DATA_W-1:0] BusWData,
    input  logic              BusGnt,
    input  logic              BusRValid,
    input  logic [DATA_W-1:0] BusRData,
    output logic              StallM,
    output logic [DATA_W-1:0] LoadDataW,
    output logic              LoadValidW,
    output logic              AdExcM
);

    memState_t   state;
    memState_t   nextState;
    accSize_t    reqSize;
    accSize_t    sizeQ;
    logic [1:0]  offsetQ;
    logic        unsignedQ;
    logic        isLoadQ;
    logic        start;
    logic        misalign;
    logic        noAccess;
    logic [31:0] alignedData;

    always_comb begin
        if (IsLbSbM)
            reqSize = SZ_BYTE;
        else if (IsLhShM)
            reqSize = SZ_HALF;
        else
            reqSize = SZ_WORD;
    end

    assign start = ReqM && (IsLoadM || IsStoreM) && !FlushM;

`ifdef ADDR_EXC_EN
    assign misalign = ((reqSize == SZ_HALF) && AddrM[0]) ||
                      ((reqSize == SZ_WORD) && (AddrM[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // A start that enables no byte lane never reaches the bus
    assign noAccess = misalign || ((BEInM & BE_ALL) == 4'b0000);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        StallM    = 1'b0;
        BusReq    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    StallM    = 1'b1;
                    nextState = noAccess ? DONE : ADDR;
                end
            end
            ADDR: begin
                BusReq = 1'b1;
                StallM = 1'b1;
                if (BusGnt)
                    nextState = isLoadQ ? DATA : DONE;
            end
            DATA: begin
                StallM = 1'b1;
                if (BusRValid)
                    nextState = DONE;
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    load_align_ext uAlign (
        .rData      (BusRData),
        .offset     (offsetQ),
        .size       (sizeQ),
        .isUnsigned (unsignedQ),
        .result     (alignedData)
    );

    // Request attributes are captured once and held stable until the next start
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            BusAddr    <= '0;
            BusBE      <= 4'b0000;
            BusWData   <= '0;
            BusWe      <= 1'b0;
            offsetQ    <= 2'b00;
            sizeQ      <= SZ_WORD;
            unsignedQ  <= 1'b0;
            isLoadQ    <= 1'b0;
            LoadDataW  <= '0;
            LoadValidW <= 1'b0;
        end else begin
            LoadValidW <= 1'b0;
            if ((state == IDLE) && start) begin
                if (!noAccess) begin
                    BusAddr   <= {AddrM[ADDR_W-1:2], AddrM[1:0] & BUS_ADDR_ALIGN_MASK};
                    BusBE     <= BEInM;
                    BusWData  <= storeLanes(reqSize, WDataM);
                    BusWe     <= !IsLoadM;
                    offsetQ   <= AddrM[1:0];
                    sizeQ     <= reqSize;
                    unsignedQ <= LoadUnsignedM;
                    isLoadQ   <= IsLoadM;
                end else if (!misalign && IsLoadM) begin
                    LoadDataW  <= '0;
                    LoadValidW <= 1'b1;
                end
            end
            if ((state == DATA) && BusRValid) begin
                LoadDataW  <= alignedData;
                LoadValidW <= 1'b1;
            end
        end
    end

`ifdef ADDR_EXC_EN
    logic adExcQ;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            adExcQ <= 1'b0;
        else
            adExcQ <= (state == IDLE) && start && misalign;
    end

    assign AdExcM = adExcQ;
`else
    assign AdExcM = 1'b0;
`endif

endmodule
